// File: rtl/spi_mem_bridge.sv
// SPI master bridge: turns one start/done request into a mode-0 SPI flash read (0x03) or write (0x02).
// Optional macro SPI_WRITE_EN enables write transfers; without it every request is a read.
module spi_mem_bridge (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_write,
   input  logic [23:0] addr,
   input  logic [2:0]  num_bytes,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        busy,
   output logic        sclk,
   output logic        mosi,
   output logic        cs_n,
   input  logic        miso
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e      state_q, state_d;
   logic        phase_q, phase_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [5:0]  last_bit_q, last_bit_d;
   logic [63:0] shreg_q, shreg_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rd_q, rd_d;

   logic        nb_valid;
   logic        wr;
   logic [63:0] frame;

   assign nb_valid = (num_bytes != 3'd0) && (num_bytes <= 3'd4);

`ifdef SPI_WRITE_EN
   assign wr    = is_write;
   assign frame = {(wr ? 8'h02 : 8'h03), addr,
                   (wr ? {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]} : 32'h0)};
`else
   logic unused_wr_inputs;
   assign unused_wr_inputs = ^{is_write, wdata};
   assign wr    = 1'b0;
   assign frame = {8'h03, addr, 32'h0};
`endif

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_cnt_d  = bit_cnt_q;
      last_bit_d = last_bit_q;
      shreg_d    = shreg_q;
      rdata_d    = rdata_q;
      rd_d       = rd_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               rd_d       = ~wr;
               bit_cnt_d  = 6'd0;
               phase_d    = 1'b0;
               last_bit_d = 6'd31 + {num_bytes, 3'b000};
               shreg_d    = frame;
               if (!wr || !nb_valid) rdata_d = 32'h0;
               state_d    = nb_valid ? StShift : StDone;
            end
         end
         StShift: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               // End of high phase: sample miso, advance to the next bit.
               phase_d   = 1'b0;
               shreg_d   = {shreg_q[62:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (rd_q && bit_cnt_q[5]) rdata_d[{bit_cnt_q[4:3], ~bit_cnt_q[2:0]}] = miso;
               if (bit_cnt_q == last_bit_q) state_d = StDone;
            end
         end
         StDone: begin
            if (!start) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         phase_q    <= 1'b0;
         bit_cnt_q  <= 6'd0;
         last_bit_q <= 6'd0;
         shreg_q    <= 64'h0;
         rdata_q    <= 32'h0;
         rd_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_cnt_q  <= bit_cnt_d;
         last_bit_q <= last_bit_d;
         shreg_q    <= shreg_d;
         rdata_q    <= rdata_d;
         rd_q       <= rd_d;
      end
   end

   assign rdata = rdata_q;
   assign busy  = (state_q != StIdle);
   assign done  = (state_q == StDone);
   assign cs_n  = (state_q != StShift);
   assign sclk  = (state_q == StShift) & phase_q;
   assign mosi  = (state_q == StShift) & shreg_q[63];

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Self-checking bench for spi_mem_bridge: SPI slave model, transaction-level reference model
// compared every cycle, plus directed transfers with hand-computed expectations.
module tb_spi_mem_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_write = 1'b0;
   logic [23:0] addr = 24'h0;
   logic [2:0]  num_bytes = 3'd0;
   logic [31:0] wdata = 32'h0;
   logic        miso;
   logic [31:0] rdata;
   logic        done, busy, sclk, mosi, cs_n;

`ifdef SPI_WRITE_EN
   localparam bit WrEn = 1'b1;
`else
   localparam bit WrEn = 1'b0;
`endif

   spi_mem_bridge dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_write  (is_write),
      .addr      (addr),
      .num_bytes (num_bytes),
      .wdata     (wdata),
      .rdata     (rdata),
      .done      (done),
      .busy      (busy),
      .sclk      (sclk),
      .mosi      (mosi),
      .cs_n      (cs_n),
      .miso      (miso)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // SPI slave: captures mosi on each completed high phase, serves sl_bytes after 32 bits.
   logic [7:0]  sl_bytes [4];
   int          sl_idx = 0;
   logic [63:0] cap = 64'h0;
   int          cs_low_cnt = 0;
   logic [7:0]  sl_cur;

   always @(posedge clk) begin
      if (cs_n) begin
         sl_idx <= 0;
      end else begin
         cs_low_cnt <= cs_low_cnt + 1;
         if (sclk) begin
            cap    <= {cap[62:0], mosi};
            sl_idx <= sl_idx + 1;
         end
      end
   end

   always_comb begin
      miso   = 1'b0;
      sl_cur = 8'h0;
      if (sl_idx >= 32 && sl_idx < 64) begin
         sl_cur = sl_bytes[(sl_idx - 32) >> 3];
         miso   = sl_cur[7 - ((sl_idx - 32) & 7)];
      end
   end

   // Reference model: mode 0 idle, 1 transferring, 2 done.
   int          m_mode = 0;
   int          m_rel = 0;
   int          m_n = 0;
   logic        m_wr = 1'b0;
   logic [63:0] m_frame = 64'h0;
   logic [31:0] m_rdata = 32'h0;
   logic [31:0] m_rfinal = 32'h0;

   function automatic logic [63:0] frame_of(input logic w, input logic [23:0] a,
                                            input logic [31:0] d);
      return {(w ? 8'h02 : 8'h03), a, d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic [31:0] exp_rd(input int nb);
      logic [31:0] r;
      r = 32'h0;
      for (int k = 0; k < nb; k++) r = r | ({24'h0, sl_bytes[k]} << (8 * k));
      return r;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_mode  <= 0;
         m_rdata <= 32'h0;
      end else begin
         case (m_mode)
            0: if (start) begin
               if (num_bytes == 3'd0 || num_bytes > 3'd4) begin
                  m_mode  <= 2;
                  m_rdata <= 32'h0;
               end else begin
                  m_mode   <= 1;
                  m_rel    <= 1;
                  m_n      <= 32 + 8 * int'(num_bytes);
                  m_wr     <= WrEn && is_write;
                  m_frame  <= frame_of(WrEn && is_write, addr, wdata);
                  if (!(WrEn && is_write)) m_rdata <= 32'h0;
                  m_rfinal <= (WrEn && is_write) ? m_rdata : exp_rd(int'(num_bytes));
               end
            end
            1: begin
               m_rel <= m_rel + 1;
               if (m_rel == 2 * m_n) begin
                  m_mode  <= 2;
                  m_rdata <= m_rfinal;
               end
            end
            2: if (!start) m_mode <= 0;
            default: m_mode <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         case (m_mode)
            0: begin
               check("idle_outputs", {cs_n, sclk, mosi, busy, done}, 5'b10000);
               check("idle_rdata", rdata, m_rdata);
            end
            1: begin
               check("shift_ctrl", {cs_n, sclk, busy, done},
                     {1'b0, (m_rel % 2 == 0), 1'b1, 1'b0});
               // mosi during read data bytes is unconstrained
               if (m_wr || ((m_rel - 1) / 2) < 32)
                  check("shift_mosi", mosi, m_frame[63 - (m_rel - 1) / 2]);
            end
            default: begin
               check("done_outputs", {cs_n, sclk, mosi, busy, done}, 5'b10011);
               check("done_rdata", rdata, m_rdata);
            end
         endcase
      end
   end

   // Call just after a negedge. Scrambles inputs once latched to show they are ignored.
   task automatic xfer(input logic w, input logic [23:0] a, input logic [2:0] nb,
                       input logic [31:0] wd, input int drop_at, input int hold,
                       output int done_cyc);
      is_write  = w;
      addr      = a;
      num_bytes = nb;
      wdata     = wd;
      start     = 1'b1;
      done_cyc  = -1;
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 1) begin
            is_write  = ~w;
            addr      = ~a;
            num_bytes = 3'd3;
            wdata     = ~wd;
         end
         if (c == drop_at) start = 1'b0;
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      if (done_cyc < 0) check("done_timeout", 0, 1);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         check("done_held", {done, cs_n}, 2'b11);
      end
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("release_idle", {busy, done}, 2'b00);
   endtask

   int          dc;
   int          cs0;
   logic [31:0] r_prev;

   initial begin
      sl_bytes[0] = 8'h0; sl_bytes[1] = 8'h0; sl_bytes[2] = 8'h0; sl_bytes[3] = 8'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("reset_outputs", {cs_n, sclk, mosi, busy, done}, 5'b10000);
      check("reset_rdata", rdata, 32'h0);

      // 4-byte read, start raised together with reset release
      sl_bytes[0] = 8'h13; sl_bytes[1] = 8'h05; sl_bytes[2] = 8'h00; sl_bytes[3] = 8'h00;
      rst_n = 1'b1;
      cs0 = cs_low_cnt;
      xfer(1'b0, 24'h000010, 3'd4, 32'h0, 0, 0, dc);
      check("rd4_done_cycle", dc, 129);
      check("rd4_cmd_addr", cap[63:32], 32'h03000010);
      check("rd4_rdata", rdata, 32'h00000513);
      check("rd4_cs_cycles", cs_low_cnt - cs0, 128);

      // 1-byte read
      sl_bytes[0] = 8'h80;
      cs0 = cs_low_cnt;
      xfer(1'b0, 24'h0000FF, 3'd1, 32'h0, 0, 0, dc);
      check("rd1_done_cycle", dc, 81);
      check("rd1_cmd_addr", cap[39:8], 32'h030000FF);
      check("rd1_rdata", rdata, 32'h00000080);
      check("rd1_cs_cycles", cs_low_cnt - cs0, 80);

      // 2-byte read with start held 5 cycles past done
      sl_bytes[0] = 8'hA5; sl_bytes[1] = 8'h5A;
      cs0 = cs_low_cnt;
      xfer(1'b0, 24'h000100, 3'd2, 32'h0, 0, 5, dc);
      check("hold_done_cycle", dc, 97);
      check("hold_rdata", rdata, 32'h00005AA5);
      check("hold_no_second", cs_low_cnt - cs0, 96);

      // Invalid lengths: no SPI activity, done next cycle, rdata cleared
      cs0 = cs_low_cnt;
      xfer(1'b0, 24'h000020, 3'd0, 32'h0, 0, 2, dc);
      check("nb0_done_cycle", dc, 1);
      check("nb0_rdata", rdata, 32'h0);
      check("nb0_no_cs", cs_low_cnt - cs0, 0);
      sl_bytes[0] = 8'h44;
      xfer(1'b0, 24'h000020, 3'd1, 32'h0, 0, 0, dc);
      cs0 = cs_low_cnt;
      xfer(1'b0, 24'h000020, 3'd6, 32'h0, 0, 0, dc);
      check("nb6_done_cycle", dc, 1);
      check("nb6_rdata", rdata, 32'h0);
      check("nb6_no_cs", cs_low_cnt - cs0, 0);

      // start dropped mid-transfer: transfer still completes
      sl_bytes[0] = 8'h11; sl_bytes[1] = 8'h22; sl_bytes[2] = 8'h33;
      xfer(1'b0, 24'h0ABCDE, 3'd3, 32'h0, 10, 0, dc);
      check("drop_done_cycle", dc, 113);
      check("drop_rdata", rdata, 32'h00332211);

`ifdef SPI_WRITE_EN
      r_prev = rdata;
      xfer(1'b1, 24'h001234, 3'd2, 32'hAABBCCDD, 0, 0, dc);
      check("wr2_done_cycle", dc, 97);
      check("wr2_frame", cap[47:0], 48'h02001234DDCC);
      check("wr2_rdata_kept", rdata, r_prev);
`else
      // Write request with writes compiled out: plain read, wdata ignored
      sl_bytes[0] = 8'h77; sl_bytes[1] = 8'h66;
      r_prev = rdata;
      xfer(1'b1, 24'h00ABCD, 3'd2, 32'hDEADBEEF, 0, 0, dc);
      check("nowr_done_cycle", dc, 97);
      check("nowr_cmd_addr", cap[47:16], 32'h0300ABCD);
      check("nowr_rdata", rdata, 32'h00006677);
`endif

      // Reset asserted at cycle 20 of a read
      sl_bytes[0] = 8'h13; sl_bytes[1] = 8'h05; sl_bytes[2] = 8'h00; sl_bytes[3] = 8'h00;
      is_write = 1'b0; addr = 24'h000010; num_bytes = 3'd4; start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("pre_reset_busy", {busy, cs_n}, 2'b10);
      rst_n = 1'b0;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_reset_outputs", {cs_n, sclk, busy, done}, 4'b1000);
      check("mid_reset_rdata", rdata, 32'h0);
      rst_n = 1'b1;
      xfer(1'b0, 24'h000010, 3'd4, 32'h0, 0, 0, dc);
      check("post_reset_done_cycle", dc, 129);
      check("post_reset_rdata", rdata, 32'h00000513);

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
